// File: rtl/bytecode_prefetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bytecode_prefetch_ctrl_pkg
// Purpose  : Shared JVM front-end definitions: prefetch FSM state encoding
//            and the default bytecode address width.
// Revision : 1.0 - initial release
// ============================================================================
package bytecode_prefetch_ctrl_pkg;

   localparam int DEFAULT_ADDRESS_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } pf_state_t;

endpackage
`default_nettype wire

// File: rtl/bytecode_prefetch_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_fifo
// Purpose  : DEPTH x 8 bytecode FIFO with occupancy count, synchronous clear
//            and a combinational view of the head entry.
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Writes are dropped when full and reads when empty, so the count can
   // never leave the 0..DEPTH range even if the controller misbehaves.
   assign do_push = push && (count < CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   // Data storage: no reset needed, entries are only visible through count.
   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); clear wins over push/pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/bytecode_prefetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bytecode_prefetch_ctrl
// Purpose  : Bytecode prefetch controller. Issues one fetch at a time to the
//            next-byte generator, buffers returned bytes in a small FIFO,
//            tracks the bytecode PC of the head and handles branch flushes,
//            discarding any fetch that was in flight when the flush arrived.
// Revision : 1.0 - initial release
// ============================================================================
module bytecode_prefetch_ctrl
   import bytecode_prefetch_ctrl_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int DEPTH         = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     mem_start,
   input  logic                     mem_ready,
   input  logic [7:0]               mem_byte,
   output logic                     mem_pc_load,
   output logic [ADDRESS_WIDTH-1:0] mem_pc,
   output logic                     byte_valid,
   output logic [7:0]               byte_out,
   output logic [ADDRESS_WIDTH-1:0] byte_pc,
   input  logic                     byte_take,
   input  logic                     flush,
   input  logic [ADDRESS_WIDTH-1:0] flush_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   pf_state_t        state;
   logic [CW-1:0]    count;
   logic             push;
   logic             pop;

   // A returned byte is kept only when it answers a live (non-flushed) fetch;
   // flush also suppresses the pop so the head PC reload is not disturbed.
   assign push       = (state == ST_WAIT) && mem_ready && !flush;
   assign pop        = byte_take && byte_valid && !flush;
   assign byte_valid = (count != '0);

   prefetch_fifo #(
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (push),
      .push_data (mem_byte),
      .pop       (pop),
      .head      (byte_out),
      .count     (count)
   );

   // Fetch FSM with registered request/reload outputs. A fetch is issued only
   // from IDLE with a free slot, so the returning byte always has room.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         mem_start   <= 1'b0;
         mem_pc_load <= 1'b0;
         mem_pc      <= '0;
      end else begin
         mem_start   <= 1'b0;
         mem_pc_load <= flush;
         if (flush) begin
            mem_pc <= flush_pc;
         end
         case (state)
            ST_IDLE: begin
               // mem_ready here is stale (e.g. a fetch cut off by reset).
               if (!flush && (count < CW'(DEPTH))) begin
                  mem_start <= 1'b1;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_ready) begin
                  state <= ST_IDLE;
               end else if (flush) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // The in-flight byte belongs to the old stream; swallow it.
               // A repeated flush just stays here with the newer target.
               if (mem_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Head PC tracking: flush reloads, each accepted pop advances by one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_pc <= '0;
      end else if (flush) begin
         byte_pc <= flush_pc;
      end else if (pop) begin
         byte_pc <= byte_pc + ADDRESS_WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bytecode_prefetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bytecode_prefetch_ctrl
// Purpose  : Self-checking bench for bytecode_prefetch_ctrl with a queue-based
//            reference model and a latency-programmable byte generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bytecode_prefetch_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_start;
   logic        mem_ready = 1'b0;
   logic [7:0]  mem_byte = 8'h00;
   logic        mem_pc_load;
   logic [15:0] mem_pc;
   logic        byte_valid;
   logic [7:0]  byte_out;
   logic [15:0] byte_pc;
   logic        byte_take = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] flush_pc = 16'h0000;

   bytecode_prefetch_ctrl #(
      .ADDRESS_WIDTH (16),
      .DEPTH         (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_start   (mem_start),
      .mem_ready   (mem_ready),
      .mem_byte    (mem_byte),
      .mem_pc_load (mem_pc_load),
      .mem_pc      (mem_pc),
      .byte_valid  (byte_valid),
      .byte_out    (byte_out),
      .byte_pc     (byte_pc),
      .byte_take   (byte_take),
      .flush       (flush),
      .flush_pc    (flush_pc)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: bytes the consumer should see, head PC, fetch bookkeeping.
   logic [7:0]  byte_q[$];
   logic [15:0] m_pc      = 16'h0000;
   logic [15:0] m_mem_pc  = 16'h0000;
   bit          m_outst   = 1'b0;
   bit          m_discard = 1'b0;

   // Generator: answers each request after lat cycles (0 = random 1..4).
   int          lat       = 3;
   int          pend      = 0;
   logic [7:0]  next_byte = 8'h10;
   int          n_starts  = 0;
   int          n_loads   = 0;
   bit          saw_aa    = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      byte_q.delete();
      m_pc      = 16'h0000;
      m_mem_pc  = 16'h0000;
      m_outst   = 1'b0;
      m_discard = 1'b0;
      pend      = 0;
   endtask

   // One clock: drive inputs, predict from the model, clock, compare.
   task automatic step(input bit f, input logic [15:0] fpc, input bit take, input bit stale);
      bit exp_start;
      int had;
      flush     = f;
      flush_pc  = fpc;
      byte_take = take;
      mem_ready = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            mem_ready = 1'b1;
            mem_byte  = next_byte;
            next_byte = next_byte + 8'd1;
         end
      end
      if (stale) begin
         mem_ready = 1'b1;
         mem_byte  = 8'hEE;
      end
      exp_start = !m_outst && !f && (byte_q.size() < DEPTH);
      had = byte_q.size();
      if (f) begin
         byte_q.delete();
         m_pc     = fpc;
         m_mem_pc = fpc;
         if (m_outst) begin
            if (mem_ready) begin
               m_outst   = 1'b0;
               m_discard = 1'b0;
            end else begin
               m_discard = 1'b1;
            end
         end
      end else begin
         if (m_outst && mem_ready) begin
            if (!m_discard) byte_q.push_back(mem_byte);
            m_outst   = 1'b0;
            m_discard = 1'b0;
         end
         if (take && had > 0) begin
            void'(byte_q.pop_front());
            m_pc = m_pc + 16'd1;
         end
      end
      if (exp_start) m_outst = 1'b1;
      @(posedge clk);
      #1;
      if (mem_start) begin
         n_starts++;
         pend = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
      end
      if (mem_pc_load) n_loads++;
      if (byte_valid && byte_out == 8'hAA) saw_aa = 1'b1;
      chk("mem_start", 32'(mem_start), 32'(exp_start));
      chk("mem_pc_load", 32'(mem_pc_load), 32'(f));
      chk("mem_pc", 32'(mem_pc), 32'(m_mem_pc));
      chk("byte_valid", 32'(byte_valid), 32'(byte_q.size() != 0));
      chk("byte_pc", 32'(byte_pc), 32'(m_pc));
      if (byte_q.size() != 0) chk("byte_out", 32'(byte_out), 32'(byte_q[0]));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mem_start"}, 32'(mem_start), 32'd0);
      chk({tag, "_mem_pc_load"}, 32'(mem_pc_load), 32'd0);
      chk({tag, "_mem_pc"}, 32'(mem_pc), 32'd0);
      chk({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
      chk({tag, "_byte_pc"}, 32'(byte_pc), 32'd0);
   endtask

   initial begin
      // Reset state
      #12;
      chk_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      // Fill with latency 3, no takes: exactly DEPTH requests then silence
      lat = 3; next_byte = 8'h10; n_starts = 0;
      for (int i = 0; i < 30; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
      chk("fill_starts", 32'(n_starts), 32'(DEPTH));
      chk("fill_valid", 32'(byte_valid), 32'd1);
      chk("fill_count", 32'(dut.u_fifo.count), 32'(DEPTH));
      chk("fill_head", 32'(byte_out), 32'h10);

      // Flush with buffered bytes
      n_loads = 0; next_byte = 8'hAA;
      step(1'b1, 16'h0040, 1'b0, 1'b0);
      chk("flush_valid", 32'(byte_valid), 32'd0);
      chk("flush_mem_pc", 32'(mem_pc), 32'h0040);
      chk("flush_byte_pc", 32'(byte_pc), 32'h0040);
      step(1'b0, 16'h0, 1'b0, 1'b0);
      chk("flush_one_load", 32'(n_loads), 32'd1);
      chk("refetch_issued", 32'(mem_start), 32'd1);

      // Flush while the 0xAA fetch is in flight: 0xAA must be discarded
      step(1'b1, 16'h0100, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
      chk("drain_no_aa", 32'(saw_aa), 32'd0);
      chk("drain_head", 32'(byte_out), 32'hAB);
      chk("drain_pc", 32'(byte_pc), 32'h0100);

      // Full FIFO drained every cycle, refilled every other cycle
      lat = 1; next_byte = 8'h30;
      step(1'b1, 16'h0200, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
      chk("stream_full", 32'(dut.u_fifo.count), 32'(DEPTH));
      for (int i = 0; i < 24; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("stream_no_overflow", 32'(dut.u_fifo.count <= DEPTH), 32'd1);

      // PC wrap at the top of the address space
      step(1'b1, 16'hFFFF, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("pc_wrap", 32'(byte_pc), 32'h0000);

      // Randomized traffic against the model
      lat = 0;
      for (int i = 0; i < 400; i++) begin
         next_byte = 8'($urandom);
         step(($urandom_range(0, 19) == 0), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end

      // Reset in the middle of a fetch, then a stale mem_ready
      lat = 3;
      step(1'b1, 16'h0300, 1'b0, 1'b0);
      n_starts = 0;
      for (int i = 0; i < 6 && n_starts == 0; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
      chk("rst_fetch_seen", 32'(n_starts), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      chk_reset_outputs("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      next_byte = 8'h55;
      step(1'b0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
      chk("post_rst_head", 32'(byte_out), 32'h55);
      chk("post_rst_pc", 32'(byte_pc), 32'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
